// File: rtl/stage_ex_mc_pkg.sv
// Shared types for the execute stage: ALU functions, operand selects, flags and FSM states.
package stage_ex_mc_pkg;

    localparam int THREAD_W = 2;
    localparam int CNT_W    = 4;

    typedef logic [THREAD_W-1:0] threadid_t;

    typedef enum logic [2:0] {
        FN_ADD,
        FN_SUB,
        FN_AND,
        FN_OR,
        FN_XOR,
        FN_SLL,
        FN_SRL,
        FN_SLTU
    } func_t;

    typedef enum logic {A_REG, A_PC}   mux_a_t;
    typedef enum logic {B_REG, B_IMM}  mux_b_t;
    typedef enum logic {TLBW_OFF, TLBW_ON} tlbwrite_t;

    typedef struct packed {
        logic      mem;
        logic      store;
        logic      isbyte;
        logic      mul;
        logic      isreg;
        logic      jump;
        logic      branch;
        logic      iret;
        tlbwrite_t tlbwrite;
    } ex_flags_t;

    typedef enum logic {IDLE, MUL_BUSY} ex_state_t;

    // An itlb miss must never occupy the multiplier, and TLB writes are not carried out here.
    function automatic ex_flags_t effectiveFlags(ex_flags_t f, logic itlbMiss);
        ex_flags_t r;
        r          = f;
        r.mul      = f.mul & ~itlbMiss;
        r.tlbwrite = TLBW_OFF;
        return r;
    endfunction

endpackage

// File: rtl/stage_ex_mc_if.sv
// ID/EX/TL handshake bundle for stage_ex_mc.
// With STAGE_EX_FWD_EN defined the bundle also carries the source register ids id_src1/id_src2.
interface stage_ex_mc_if #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
);
    import stage_ex_mc_pkg::*;

    logic             id_valid;
    logic             id_stall;
    threadid_t        id_thread;
    logic             id_itlb_miss;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_r1;
    logic [XLEN-1:0]  id_r2;
    logic [XLEN-1:0]  id_imm;
    mux_a_t           id_a;
    mux_b_t           id_b;
    func_t            id_alu_func;
    logic [REG_W-1:0] id_dst;
    ex_flags_t        id_flags;
    logic [XLEN-1:0]  id_rm4;
`ifdef STAGE_EX_FWD_EN
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
`endif

    logic             tl_stall;
    logic             tl_valid;
    threadid_t        tl_thread;
    logic             tl_itlb_miss;
    logic [XLEN-1:0]  tl_pc;
    logic [XLEN-1:0]  tl_r2;
    logic [REG_W-1:0] tl_dst;
    ex_flags_t        tl_flags;
    logic [XLEN-1:0]  tl_rm4;
    logic [XLEN-1:0]  tl_data;
    logic [XLEN-1:0]  tl_mul;
    logic             tl_isequal;

    modport slave (
        input  id_valid, id_thread, id_itlb_miss, id_pc, id_r1, id_r2, id_imm, id_a, id_b,
               id_alu_func, id_dst, id_flags, id_rm4,
`ifdef STAGE_EX_FWD_EN
               id_src1, id_src2,
`endif
               tl_stall,
        output id_stall, tl_valid, tl_thread, tl_itlb_miss, tl_pc, tl_r2, tl_dst, tl_flags,
               tl_rm4, tl_data, tl_mul, tl_isequal
    );

    modport master (
        output id_valid, id_thread, id_itlb_miss, id_pc, id_r1, id_r2, id_imm, id_a, id_b,
               id_alu_func, id_dst, id_flags, id_rm4,
`ifdef STAGE_EX_FWD_EN
               id_src1, id_src2,
`endif
               tl_stall,
        input  id_stall, tl_valid, tl_thread, tl_itlb_miss, tl_pc, tl_r2, tl_dst, tl_flags,
               tl_rm4, tl_data, tl_mul, tl_isequal
    );

endinterface

// File: rtl/stage_ex_mc_mul_pipe.sv
// Multi-cycle unsigned multiplier: captures operands on in_valid_i and counts the latency
// down on every cycle advance_i is high; out_valid_o marks the final busy cycle.
module mul_pipe
    import stage_ex_mc_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            advance_i,
    output logic            out_valid_o,
    output logic [XLEN-1:0] c_o
);
    logic [XLEN-1:0]  opA_q, opB_q, srcA, srcB;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid_i) begin
            cnt_d = CNT_W'(MUL_LAT - 1);
        end else if (advance_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            opA_q <= '0;
            opB_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (in_valid_i) begin
                opA_q <= a_i;
                opB_q <= b_i;
            end
        end
    end

    // Live operands feed the multiplier when nothing is in flight, which covers MUL_LAT == 1.
    assign srcA        = (cnt_q != '0) ? opA_q : a_i;
    assign srcB        = (cnt_q != '0) ? opB_q : b_i;
    assign c_o         = srcA * srcB;
    assign out_valid_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/stage_ex_mc.sv
// Execute stage: ALU, branch compare and a multi-cycle multiplier behind a valid/stall handshake.
// Define STAGE_EX_FWD_EN to forward the TL-stage result into the ID register operands.
module stage_ex_mc
    import stage_ex_mc_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 4,
    parameter int REG_W   = 5
) (
    input logic          clk,
    input logic          rst,
    stage_ex_mc_if.slave ex
);
    localparam int SHW = $clog2(XLEN);

    ex_state_t        state_q, state_d;
    logic [XLEN-1:0]  r1, r2, opA, opB, mulC;
    logic             idStall, accept, startBusy, mulDone;
    ex_flags_t        flags;

    logic             tlValid_q, tlItlb_q, tlIsEqual_q;
    threadid_t        tlThread_q;
    logic [XLEN-1:0]  tlPc_q, tlR2_q, tlRm4_q, tlData_q, tlMul_q;
    logic [REG_W-1:0] tlDst_q;
    ex_flags_t        tlFlags_q;

    function automatic logic [XLEN-1:0] alu(func_t f, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        case (f)
            FN_ADD:  return a + b;
            FN_SUB:  return a - b;
            FN_AND:  return a & b;
            FN_OR:   return a | b;
            FN_XOR:  return a ^ b;
            FN_SLL:  return a << b[SHW-1:0];
            FN_SRL:  return a >> b[SHW-1:0];
            FN_SLTU: return {{(XLEN-1){1'b0}}, a < b};
            default: return '0;
        endcase
    endfunction

`ifdef STAGE_EX_FWD_EN
    logic             fwdHit;
    logic [XLEN-1:0]  fwdVal;
    assign fwdVal = tlFlags_q.mul ? tlMul_q : tlData_q;
    assign fwdHit = tlValid_q & tlFlags_q.isreg & ~tlFlags_q.mem
                  & (tlThread_q == ex.id_thread) & (tlDst_q != '0);
    assign r1 = (fwdHit && tlDst_q == ex.id_src1) ? fwdVal : ex.id_r1;
    assign r2 = (fwdHit && tlDst_q == ex.id_src2) ? fwdVal : ex.id_r2;
`else
    assign r1 = ex.id_r1;
    assign r2 = ex.id_r2;
`endif

    assign flags     = effectiveFlags(ex.id_flags, ex.id_itlb_miss);
    assign opA       = (ex.id_a == A_REG) ? r1 : ex.id_pc;
    assign opB       = (ex.id_b == B_REG) ? r2 : ex.id_imm;
    assign idStall   = ex.tl_stall | (state_q == MUL_BUSY);
    assign accept    = ex.id_valid & ~idStall;
    assign startBusy = accept & flags.mul & (MUL_LAT > 1);

    mul_pipe #(
        .XLEN    (XLEN),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (startBusy),
        .a_i         (r1),
        .b_i         (r2),
        .advance_i   (~ex.tl_stall),
        .out_valid_o (mulDone),
        .c_o         (mulC)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (startBusy) state_d = MUL_BUSY;
            MUL_BUSY: if (!ex.tl_stall && mulDone) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Side fields are captured at accept and held through the busy cycles; completion only adds the product.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tlValid_q   <= 1'b0;
            tlThread_q  <= '0;
            tlItlb_q    <= 1'b0;
            tlPc_q      <= '0;
            tlR2_q      <= '0;
            tlDst_q     <= '0;
            tlFlags_q   <= '0;
            tlRm4_q     <= '0;
            tlData_q    <= '0;
            tlMul_q     <= '0;
            tlIsEqual_q <= 1'b0;
        end else if (!ex.tl_stall) begin
            if (state_q == IDLE) begin
                tlValid_q   <= ex.id_valid & ~startBusy;
                tlThread_q  <= ex.id_thread;
                tlItlb_q    <= ex.id_itlb_miss;
                tlPc_q      <= ex.id_pc;
                tlR2_q      <= r2;
                tlDst_q     <= ex.id_dst;
                tlFlags_q   <= flags;
                tlRm4_q     <= ex.id_rm4;
                tlData_q    <= alu(ex.id_alu_func, opA, opB);
                tlMul_q     <= mulC;
                tlIsEqual_q <= (r1 == r2);
            end else begin
                tlValid_q <= mulDone;
                if (mulDone) begin
                    tlMul_q <= mulC;
                end
            end
        end
    end

    assign ex.id_stall     = idStall;
    assign ex.tl_valid     = tlValid_q;
    assign ex.tl_thread    = tlThread_q;
    assign ex.tl_itlb_miss = tlItlb_q;
    assign ex.tl_pc        = tlPc_q;
    assign ex.tl_r2        = tlR2_q;
    assign ex.tl_dst       = tlDst_q;
    assign ex.tl_flags     = tlFlags_q;
    assign ex.tl_rm4       = tlRm4_q;
    assign ex.tl_data      = tlData_q;
    assign ex.tl_mul       = tlMul_q;
    assign ex.tl_isequal   = tlIsEqual_q;

endmodule

// File: tb/tb_stage_ex_mc.sv
// Bench for stage_ex_mc: directed scenarios plus randomized traffic checked against a
// transaction-level reference (per-instruction result and remaining-latency count).
module tb_stage_ex_mc;
    import stage_ex_mc_pkg::*;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 4;
    localparam int REG_W   = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    stage_ex_mc_if #(.XLEN(XLEN), .REG_W(REG_W)) bus ();

    stage_ex_mc #(
        .XLEN    (XLEN),
        .MUL_LAT (MUL_LAT),
        .REG_W   (REG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    always #5 clk = ~clk;

    bit               mValid = 1'b0;
    bit               mKnown = 1'b0;
    bit               mMulKnown = 1'b0;
    bit               mStallAtEdge = 1'b0;
    int               mRemain = 0;
    logic [XLEN-1:0]  mData, mMul, mPc, mR2, mRm4;
    logic             mIsEq, mItlb;
    threadid_t        mThread;
    logic [REG_W-1:0] mDst;
    ex_flags_t        mFlags;

    task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] refAlu(func_t f, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        int unsigned sh;
        sh = b % XLEN;
        case (f)
            FN_ADD:  return a + b;
            FN_SUB:  return a - b;
            FN_AND:  return a & b;
            FN_OR:   return a | b;
            FN_XOR:  return a ^ b;
            FN_SLL:  return a << sh;
            FN_SRL:  return a >> sh;
            FN_SLTU: return (a < b) ? XLEN'(1) : XLEN'(0);
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] refMul(logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        return p[XLEN-1:0];
    endfunction

    // Reference state update for one rising edge, using the inputs present at that edge.
    task automatic modelEdge();
        logic [XLEN-1:0] r1, r2, a, b;
        if (!rst) begin
            mValid = 0; mRemain = 0; mKnown = 1; mMulKnown = 1;
            mData = '0; mMul = '0; mPc = '0; mR2 = '0; mRm4 = '0;
            mIsEq = 0; mItlb = 0; mThread = '0; mDst = '0; mFlags = '0;
            return;
        end
        if (bus.tl_stall) return;
        if (mRemain > 0) begin
            mRemain--;
            mValid = (mRemain == 0);
            if (mValid) mMulKnown = 1;
            return;
        end
        if (!bus.id_valid) begin
            mValid = 0; mKnown = 0; mMulKnown = 0;
            return;
        end
        r1 = bus.id_r1;
        r2 = bus.id_r2;
`ifdef STAGE_EX_FWD_EN
        if (mValid && mFlags.isreg && !mFlags.mem && mThread == bus.id_thread && mDst != 0) begin
            if (mDst == bus.id_src1) r1 = mFlags.mul ? mMul : mData;
            if (mDst == bus.id_src2) r2 = mFlags.mul ? mMul : mData;
        end
`endif
        a = (bus.id_a == A_PC) ? bus.id_pc : r1;
        b = (bus.id_b == B_IMM) ? bus.id_imm : r2;
        mFlags          = bus.id_flags;
        mFlags.tlbwrite = TLBW_OFF;
        if (bus.id_itlb_miss) mFlags.mul = 1'b0;
        mData   = refAlu(bus.id_alu_func, a, b);
        mMul    = refMul(r1, r2);
        mIsEq   = (r1 == r2);
        mPc     = bus.id_pc;
        mR2     = r2;
        mRm4    = bus.id_rm4;
        mThread = bus.id_thread;
        mDst    = bus.id_dst;
        mItlb   = bus.id_itlb_miss;
        mKnown  = 1;
        if (mFlags.mul && MUL_LAT > 1) begin
            mValid = 0; mRemain = MUL_LAT - 1; mMulKnown = 0;
        end else begin
            mValid = 1; mMulKnown = mFlags.mul;
        end
    endtask

    task automatic checkAll();
        ex_flags_t f;
        checkOutput("tl_valid", 64'(bus.tl_valid), 64'(mValid));
        if (mKnown) begin
            checkOutput("tl_pc", 64'(bus.tl_pc), 64'(mPc));
            checkOutput("tl_r2", 64'(bus.tl_r2), 64'(mR2));
            checkOutput("tl_rm4", 64'(bus.tl_rm4), 64'(mRm4));
            checkOutput("tl_thread", 64'(bus.tl_thread), 64'(mThread));
            checkOutput("tl_dst", 64'(bus.tl_dst), 64'(mDst));
            checkOutput("tl_itlb_miss", 64'(bus.tl_itlb_miss), 64'(mItlb));
            checkOutput("tl_isequal", 64'(bus.tl_isequal), 64'(mIsEq));
            checkOutput("tl_data", 64'(bus.tl_data), 64'(mData));
            f = bus.tl_flags;
            if (mItlb) f.mul = mFlags.mul;
            checkOutput("tl_flags", 64'(f), 64'(mFlags));
        end
        if (mMulKnown) checkOutput("tl_mul", 64'(bus.tl_mul), 64'(mMul));
    endtask

    // Entered just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic stepCycle();
        #1;
        mStallAtEdge = bus.tl_stall | (mRemain > 0);
        checkOutput("id_stall", 64'(bus.id_stall), 64'(mStallAtEdge));
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll();
    endtask

    task automatic setInstr(func_t f, mux_a_t sa, mux_b_t sb, logic [XLEN-1:0] r1,
                            logic [XLEN-1:0] r2, logic [XLEN-1:0] imm, logic isMul);
        bus.id_valid       = 1'b1;
        bus.id_thread      = '0;
        bus.id_itlb_miss   = 1'b0;
        bus.id_pc          = 32'h0000_0100;
        bus.id_r1          = r1;
        bus.id_r2          = r2;
        bus.id_imm         = imm;
        bus.id_a           = sa;
        bus.id_b           = sb;
        bus.id_alu_func    = f;
        bus.id_dst         = '0;
        bus.id_flags       = '0;
        bus.id_flags.mul   = isMul;
        bus.id_flags.isreg = 1'b1;
        bus.id_rm4         = 32'h0000_00A5;
`ifdef STAGE_EX_FWD_EN
        bus.id_src1 = '0;
        bus.id_src2 = '0;
`endif
    endtask

    task automatic applyStimulus();
        logic [8:0] fr;
        if (!(mStallAtEdge && bus.id_valid && rst)) begin
            bus.id_valid     = ($urandom_range(0, 3) != 0);
            bus.id_thread    = threadid_t'($urandom_range(0, 3));
            bus.id_itlb_miss = ($urandom_range(0, 7) == 0);
            bus.id_pc        = $urandom();
            bus.id_r1        = $urandom();
            bus.id_r2        = ($urandom_range(0, 3) == 0) ? bus.id_r1 : $urandom();
            bus.id_imm       = $urandom();
            bus.id_a         = mux_a_t'(1'($urandom_range(0, 1)));
            bus.id_b         = mux_b_t'(1'($urandom_range(0, 1)));
            bus.id_alu_func  = func_t'(3'($urandom_range(0, 7)));
            bus.id_dst       = REG_W'($urandom_range(0, 3));
            fr               = 9'($urandom());
            bus.id_flags     = fr;
            bus.id_flags.mul = ($urandom_range(0, 2) == 0);
            bus.id_rm4       = $urandom();
`ifdef STAGE_EX_FWD_EN
            bus.id_src1 = REG_W'($urandom_range(0, 3));
            bus.id_src2 = REG_W'($urandom_range(0, 3));
`endif
        end
        bus.tl_stall = ($urandom_range(0, 3) == 0);
        rst          = ($urandom_range(0, 79) != 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        setInstr(FN_ADD, A_REG, B_REG, '0, '0, '0, 1'b0);
        bus.id_valid = 1'b0;
        bus.tl_stall = 1'b0;
        rst          = 1'b0;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll();
        stepCycle();
        rst = 1'b1;

        $display("[TB] ADD 5 + imm 7");
        setInstr(FN_ADD, A_REG, B_IMM, 32'd5, 32'd0, 32'd7, 1'b0);
        stepCycle();
        checkOutput("t1_valid", 64'(bus.tl_valid), 64'd1);
        checkOutput("t1_data", 64'(bus.tl_data), 64'd12);

        $display("[TB] MUL latency");
        setInstr(FN_ADD, A_REG, B_REG, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b1);
        stepCycle();
        bus.id_valid = 1'b0;
        n = 1;
        while (bus.tl_valid !== 1'b1 && n < 20) begin
            stepCycle();
            n++;
        end
        checkOutput("t2_latency", 64'(n), 64'(MUL_LAT));
        checkOutput("t2_mul", 64'(bus.tl_mul), 64'h0000_0000_FFFF_FFFE);

        $display("[TB] MUL with a 2-cycle TL stall");
        setInstr(FN_OR, A_REG, B_REG, 32'd7, 32'd9, 32'd0, 1'b1);
        stepCycle();
        bus.id_valid = 1'b0;
        stepCycle();
        bus.tl_stall = 1'b1;
        stepCycle();
        stepCycle();
        bus.tl_stall = 1'b0;
        n = 4;
        while (bus.tl_valid !== 1'b1 && n < 24) begin
            stepCycle();
            n++;
        end
        checkOutput("t3_latency", 64'(n), 64'(MUL_LAT + 2));
        checkOutput("t3_mul", 64'(bus.tl_mul), 64'd63);

        $display("[TB] reset during MUL_BUSY");
        setInstr(FN_ADD, A_REG, B_REG, 32'd3, 32'd5, 32'd0, 1'b1);
        stepCycle();
        bus.id_valid = 1'b0;
        stepCycle();
        rst = 1'b0;
        stepCycle();
        rst = 1'b1;
        checkOutput("t4_valid", 64'(bus.tl_valid), 64'd0);
        checkOutput("t4_stall", 64'(bus.id_stall), 64'd0);
        setInstr(FN_ADD, A_REG, B_IMM, 32'd3, 32'd0, 32'd4, 1'b0);
        stepCycle();
        checkOutput("t4_valid2", 64'(bus.tl_valid), 64'd1);
        checkOutput("t4_data", 64'(bus.tl_data), 64'd7);

        $display("[TB] branch compare");
        setInstr(FN_SUB, A_REG, B_REG, 32'h1234, 32'h1234, 32'd0, 1'b0);
        bus.id_flags.branch = 1'b1;
        stepCycle();
        checkOutput("t5_equal", 64'(bus.tl_isequal), 64'd1);
        bus.id_r2 = 32'h1235;
        stepCycle();
        checkOutput("t5_notequal", 64'(bus.tl_isequal), 64'd0);

`ifdef STAGE_EX_FWD_EN
        $display("[TB] forwarding");
        setInstr(FN_ADD, A_REG, B_IMM, 32'd0, 32'd0, 32'd10, 1'b0);
        bus.id_dst = 5'd3; bus.id_thread = 2'd1;
        stepCycle();
        checkOutput("t6_first", 64'(bus.tl_data), 64'd10);
        setInstr(FN_ADD, A_REG, B_IMM, 32'd999, 32'd0, 32'd1, 1'b0);
        bus.id_thread = 2'd1; bus.id_src1 = 5'd3;
        stepCycle();
        checkOutput("t6_fwd", 64'(bus.tl_data), 64'd11);
        setInstr(FN_ADD, A_REG, B_IMM, 32'd0, 32'd0, 32'd10, 1'b0);
        bus.id_dst = 5'd3; bus.id_thread = 2'd1;
        stepCycle();
        setInstr(FN_ADD, A_REG, B_IMM, 32'd999, 32'd0, 32'd1, 1'b0);
        bus.id_thread = 2'd2; bus.id_src1 = 5'd3;
        stepCycle();
        checkOutput("t6_nofwd", 64'(bus.tl_data), 64'd1000);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
